// File: rtl/ffe_pkg.sv
// rtl/ffe_pkg.sv - shared defaults and state type for the FFE tap delay line
//
// Purpose: default sample width / tap count for the FFE datapath and the
// delay-line fill-state enumeration shared by the control logic.
package ffe_pkg;

  localparam int FFE_SAMPLE_W = 12;
  localparam int FFE_NUM_TAPS = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } ffe_dl_state_e;

endpackage : ffe_pkg

// File: rtl/ffe_tap_stage.sv
// rtl/ffe_tap_stage.sv - one WIDTH-bit tap register of the FFE delay line
//
// Purpose: sample register with load enable and synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears q_o
//   clr_i - synchronous clear, wins over en_i
//   en_i  - load d_i on this edge
//   d_i   - incoming sample
//   q_o   - stored sample
module ffe_tap_stage #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : ffe_tap_stage

// File: rtl/ffe_tap_delay_line.sv
// rtl/ffe_tap_delay_line.sv - parallel-tap sample delay line feeding the FFE MAC
//
// Purpose: DEPTH-stage shift line of WIDTH-bit samples, advancing once per
// accepted sample, with fill tracking so the MAC only starts on real data.
// Optional macro: FFE_DL_FILL_CNT_EN exposes the internal fill counter.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset, clears everything
//   in_data    - new sample
//   in_valid   - accept in_data on this edge
//   delete     - synchronous flush of taps and fill state (drops in_valid)
//   taps       - tap i at [i*WIDTH +: WIDTH], tap0 newest
//   taps_valid - one-cycle pulse: taps advanced and line is full
//   full       - all DEPTH taps hold accepted samples
//   fill_cnt   - saturating fill count (only with FFE_DL_FILL_CNT_EN)
module ffe_tap_delay_line
  import ffe_pkg::*;
#(
  parameter  int WIDTH = FFE_SAMPLE_W,
  parameter  int DEPTH = FFE_NUM_TAPS,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   delete,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic                   taps_valid,
  output logic                   full
`ifdef FFE_DL_FILL_CNT_EN
  ,
  output logic [CNT_W-1:0]       fill_cnt
`endif
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  ffe_dl_state_e    state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             taps_valid_q, taps_valid_d;

  logic [WIDTH-1:0] tap_q [DEPTH];
  logic             shift_en;

  // delete outranks in_valid inside each stage (clr over en), so a
  // colliding sample is never captured.
  assign shift_en = in_valid & ~delete;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (i == 0) begin : g_head
      assign stage_d = in_data;
    end else begin : g_body
      assign stage_d = tap_q[i-1];
    end

    ffe_tap_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (delete),
      .en_i  (shift_en),
      .d_i   (stage_d),
      .q_o   (tap_q[i])
    );

    assign taps[i*WIDTH +: WIDTH] = tap_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      fill_q       <= '0;
      taps_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      taps_valid_q <= taps_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    taps_valid_d = 1'b0;

    if (delete) begin
      state_d = EMPTY;
      fill_d  = '0;
    end else if (in_valid) begin
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end

      unique case (state_q)
        EMPTY:   state_d = FILLING;
        FILLING: if (fill_q == FILL_MAX - 1'b1) state_d = FULL;
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase

      // Pulse covers the filling accept itself as well as every later one.
      taps_valid_d = (state_d == FULL);
    end
  end

  assign full       = (state_q == FULL);
  assign taps_valid = taps_valid_q;

`ifdef FFE_DL_FILL_CNT_EN
  assign fill_cnt = fill_q;
`endif

endmodule : ffe_tap_delay_line

// File: tb/tb_ffe_tap_delay_line.sv
// tb/tb_ffe_tap_delay_line.sv - directed self-checking bench for ffe_tap_delay_line
module tb_ffe_tap_delay_line;

  localparam int W     = 12;
  localparam int D     = 8;
  localparam int CNT_W = $clog2(D + 1);

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           delete;
  logic [D*W-1:0] taps;
  logic           taps_valid;
  logic           full;
`ifdef FFE_DL_FILL_CNT_EN
  logic [CNT_W-1:0] fill_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ffe_tap_delay_line #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .delete     (delete),
    .taps       (taps),
    .taps_valid (taps_valid),
    .full       (full)
`ifdef FFE_DL_FILL_CNT_EN
    ,
    .fill_cnt   (fill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic         del;
    logic [W-1:0] data;
    logic         exp_full;
    logic         exp_tv;
    logic [W-1:0] exp_tap0;
    logic [W-1:0] exp_tap7;
    int           exp_fill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tap(input int k);
    return taps[k*W +: W];
  endfunction

  task automatic chk_fill(input string name, input int exp);
`ifdef FFE_DL_FILL_CNT_EN
    chk(name, 128'(fill_cnt), 128'(exp));
`endif
  endtask

  // Inputs are set before the edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic del, input logic [W-1:0] d);
    in_valid = iv;
    delete   = del;
    in_data  = d;
  endtask

  initial begin
    // fill 0x001..0x008
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, W'(i + 1), (i == 7), (i == 7), W'(i + 1),
                  (i == 7) ? 12'h001 : 12'h000, i + 1};
    end
    vecs[8]  = '{1'b1, 1'b0, 12'h009, 1'b1, 1'b1, 12'h009, 12'h002, 8};
    vecs[9]  = '{1'b0, 1'b0, 12'h555, 1'b1, 1'b0, 12'h009, 12'h002, 8};
    vecs[10] = '{1'b0, 1'b0, 12'h555, 1'b1, 1'b0, 12'h009, 12'h002, 8};
    vecs[11] = '{1'b1, 1'b0, 12'h00A, 1'b1, 1'b1, 12'h00A, 12'h003, 8};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h00A, 12'h003, 8};
    vecs[13] = '{1'b1, 1'b1, 12'hABC, 1'b0, 1'b0, 12'h000, 12'h000, 0};
    vecs[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 12'h000, 0};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    #12;
    rst = 1'b0;
    repeat (5) step();
    chk("reset_taps", 128'(taps), 128'(0));
    chk("reset_full", 128'(full), 128'(0));
    chk("reset_tv", 128'(taps_valid), 128'(0));
    chk_fill("reset_fill", 0);

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].iv, vecs[v].del, vecs[v].data);
      step();
      chk($sformatf("v%0d_full", v), 128'(full), 128'(vecs[v].exp_full));
      chk($sformatf("v%0d_tv", v), 128'(taps_valid), 128'(vecs[v].exp_tv));
      chk($sformatf("v%0d_tap0", v), 128'(tap(0)), 128'(vecs[v].exp_tap0));
      chk($sformatf("v%0d_tap7", v), 128'(tap(7)), 128'(vecs[v].exp_tap7));
      chk_fill($sformatf("v%0d_fill", v), vecs[v].exp_fill);
      if (v == 7) begin
        // sample accepted k samples ago sits on tap k
        for (int k = 0; k < D; k++) chk($sformatf("fill_tap%0d", k), 128'(tap(k)), 128'(8 - k));
      end
    end
    chk("delete_all_zero", 128'(taps), 128'(0));

    // async reset between edges, after 3 samples
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, W'(12'h100 + i));
      step();
    end
    drive(1'b0, 1'b0, '0);
    chk("pre_rst_tap0", 128'(tap(0)), 128'(12'h103));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_taps", 128'(taps), 128'(0));
    chk("async_rst_full", 128'(full), 128'(0));
    chk("async_rst_tv", 128'(taps_valid), 128'(0));
    chk_fill("async_rst_fill", 0);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, W'(12'h300 + i));
      step();
      chk($sformatf("refill%0d_full", i), 128'(full), 128'(i == 8));
    end
    chk("refill_tap7", 128'(tap(7)), 128'(12'h301));

    // flush, then 20 back-to-back samples
    drive(1'b0, 1'b1, '0);
    step();
    for (int n = 1; n <= 20; n++) begin
      drive(1'b1, 1'b0, W'(12'h200 + n));
      step();
      chk($sformatf("sat%0d_tv", n), 128'(taps_valid), 128'(n >= 8));
      chk($sformatf("sat%0d_full", n), 128'(full), 128'(n >= 8));
      chk($sformatf("sat%0d_tap7", n), 128'(tap(7)), 128'((n >= 8) ? (12'h200 + n - 7) : 0));
      chk($sformatf("sat%0d_tap3", n), 128'(tap(3)), 128'((n >= 4) ? (12'h200 + n - 3) : 0));
      chk_fill($sformatf("sat%0d_fill", n), (n < 8) ? n : 8);
    end
    drive(1'b0, 1'b0, '0);
    step();
    chk("sat_idle_tv", 128'(taps_valid), 128'(0));
    chk("sat_idle_tap0", 128'(tap(0)), 128'(12'h214));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ffe_tap_delay_line
